// File: rtl/mux2_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux2_rr_arbiter_pkg
// Description : Shared state encoding and defaults for the two-way
//               round-robin arbiter in front of a Mux2 datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package mux2_rr_arbiter_pkg;

  // Arbiter ownership states; encoding is fixed so debug probes stay stable.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  // Default bound on consecutive grant cycles while the other side waits.
  localparam int c_DEFAULT_MAX_HOLD = 8;

  // Default width of the hold counter.
  localparam int c_DEFAULT_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/mux2_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux2_rr_arbiter_if
// Description : Request / grant / select bundle between two requesters and
//               the round-robin arbiter driving a Mux2 select.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux2_rr_arbiter_if;

  logic req0;   // requester 0 wants the mux
  logic req1;   // requester 1 wants the mux
  logic gnt0;   // requester 0 owns the mux
  logic gnt1;   // requester 1 owns the mux
  logic s0;     // Mux2 select: 0 = I0, 1 = I1
  logic busy;   // either grant active

  // Requester side: raises requests, observes grants and select.
  modport master (
    output req0, req1,
    input  gnt0, gnt1, s0, busy
  );

  // Arbiter side: samples requests, drives grants and select.
  modport slave (
    input  req0, req1,
    output gnt0, gnt1, s0, busy
  );

endinterface
`default_nettype wire

// File: rtl/mux2_hold_counter.sv
`default_nettype none
// ============================================================================
// Module      : mux2_hold_counter
// Description : Up-counter with synchronous clear and enable that saturates
//               at LIMIT and flags when it sits at the limit.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_hold_counter #(
  parameter int CNT_W = 4,
  parameter int LIMIT = 7
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_term
);

  localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_cnt;

  // Count enabled cycles; clear wins over enable, and the count parks at LIMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_term = (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux2_rr_arbiter
// Description : Two-way round-robin arbiter sharing one Mux2. Grants are
//               held while requested, bounded to MAX_HOLD cycles whenever the
//               other requester is waiting. Grants and select are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = c_DEFAULT_MAX_HOLD,
  parameter int CNT_W    = c_DEFAULT_CNT_W
) (
  input wire logic            clk,
  input wire logic            rst_n,
  mux2_rr_arbiter_if.slave    bus
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last;     // last owner: 1 means requester 0 wins the next tie
  logic   r_gnt0;
  logic   r_gnt1;
  logic   r_s0;
  logic   w_term;     // current owner has used up its hold budget
  logic   w_enter;    // this edge hands the mux to a new owner
  logic   w_stay;     // this edge keeps the current owner

  // Hold budget for the current owner; cleared on every new grant.
  mux2_hold_counter #(
    .CNT_W (CNT_W),
    .LIMIT (MAX_HOLD - 1)
  ) u_hold_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_enter),
    .i_en   (w_stay),
    .o_term (w_term)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: ties go to the non-last requester, handovers are bubble-free.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          w_state_nxt = r_last ? OWN0 : OWN1;
        end else if (bus.req0) begin
          w_state_nxt = OWN0;
        end else if (bus.req1) begin
          w_state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!bus.req0) begin
          w_state_nxt = bus.req1 ? OWN1 : IDLE;
        end else if (bus.req1 && w_term) begin
          w_state_nxt = OWN1;
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          w_state_nxt = bus.req0 ? OWN0 : IDLE;
        end else if (bus.req0 && w_term) begin
          w_state_nxt = OWN0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_enter = (w_state_nxt != IDLE) && (w_state_nxt != r_state);
  assign w_stay  = (r_state != IDLE) && (w_state_nxt == r_state);

  // Grant, select and last-owner registers; select only moves with a new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_s0   <= 1'b0;
      r_last <= 1'b1;
    end else begin
      r_gnt0 <= (w_state_nxt == OWN0);
      r_gnt1 <= (w_state_nxt == OWN1);
      if (w_enter) begin
        r_s0   <= (w_state_nxt == OWN1);
        r_last <= (w_state_nxt == OWN1);
      end
    end
  end

  assign bus.gnt0 = r_gnt0;
  assign bus.gnt1 = r_gnt1;
  assign bus.s0   = r_s0;
  assign bus.busy = r_gnt0 | r_gnt1;

endmodule
`default_nettype wire
